// File: rtl/uart_rx_checked_if.sv
// Consumer-side bundle of the checked UART receiver: held byte, status flags
// and the valid/ready handshake.
interface uart_rx_checked_if;
  logic       rx_ready;
  logic       rx_data_valid;
  logic [7:0] rx_output;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  // Receiver side drives the byte and the flags; the consumer drives rx_ready.
  modport master (
    input  rx_ready,
    output rx_data_valid, rx_output, rx_parity_err, rx_frame_err, rx_overrun, rx_busy
  );

  modport slave (
    output rx_ready,
    input  rx_data_valid, rx_output, rx_parity_err, rx_frame_err, rx_overrun, rx_busy
  );
endinterface

// File: rtl/uart_rx_checked.sv
// Checked UART receiver. It synchronises the pin and rejects start glitches.
// It also checks optional parity and the stop bit, then holds each byte for
// a valid/ready consumer and reports overrun when a byte is dropped.
module uart_rx_checked #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic               i_Clock,
  input  logic               i_Rst_n,
  input  logic               rx_serial_input,
  uart_rx_checked_if.master  rx
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DELIVER,
    S_BREAK
  } state_t;

  logic          sync1_q, sync2_q;
  logic          rxs;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          perr_q, ferr_q;
  logic [7:0]    data_q;
  logic          valid_q, perr_out_q, ferr_out_q, overrun_q, busy_q;

  assign rxs = sync2_q;

  // Two-flop synchroniser on the asynchronous pin; idles high.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_serial_input;
      sync2_q <= sync1_q;
    end
  end

  // Receive FSM with the output holding register and handshake.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // The handshake clear comes first so that a same-cycle load or overrun
      // in the deliver state overrides it.
      if (valid_q && rx.rx_ready) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end

        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            idx_q <= '0;
            if (!rxs) begin
              state_q <= S_DATA;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rxs;
            if (idx_q == 3'd7) begin
              idx_q   <= '0;
              state_q <= PARITY_EN ? S_PARITY : S_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        S_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            perr_q  <= PARITY_EN && ((^shift_q ^ rxs) != PARITY_ODD);
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            ferr_q  <= ~rxs;
            state_q <= S_DELIVER;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        S_DELIVER: begin
          // A byte accepted in this same cycle frees the slot for the new one.
          if (!valid_q || rx.rx_ready) begin
            data_q     <= shift_q;
            perr_out_q <= perr_q;
            ferr_out_q <= ferr_q;
            valid_q    <= 1'b1;
          end else begin
            overrun_q <= 1'b1;
          end
          state_q <= ferr_q ? S_BREAK : S_IDLE;
          busy_q  <= ferr_q;
        end

        S_BREAK: begin
          if (rxs) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx.rx_data_valid = valid_q;
  assign rx.rx_output     = data_q;
  assign rx.rx_parity_err = perr_out_q;
  assign rx.rx_frame_err  = ferr_out_q;
  assign rx.rx_overrun    = overrun_q;
  assign rx.rx_busy       = busy_q;

endmodule
